// File: rtl/pipeline_fetch_if.sv
// Fetch-stage bundle: imem request/response channel, redirect/stall from later
// stages, and the {pc, instruction} pair handed to register fetch.
interface pipeline_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] pc_out;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_out, pc_out,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc, stall
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_out, pc_out,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc, stall
  );
endinterface

// File: rtl/pipeline_fetch.sv
// MIPS instruction fetch: PC, imem requests, 2-entry {pc, inst} queue; response to output in 1 cycle.
// Requests are throttled so in-flight + queued never exceeds 2; stall holds the head; redirect flushes.
module pipeline_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  pipeline_fetch_if.master bus
);
  logic [31:0] pc;
  logic [31:0] resp_pc;
  logic [1:0]  outstanding;
  logic [1:0]  drop;
  logic [1:0]  count;
  logic        rd_ptr;
  logic        wr_ptr;
  logic [31:0] q_pc   [2];
  logic [31:0] q_inst [2];

  logic        head_vld;
  logic        pop;
  logic        resp_ok;
  logic        push;
  logic        req_vld;
  logic        accept;
  logic [2:0]  inflight;
  logic [31:0] redir_target;

  always_comb begin
    head_vld     = (count != 2'd0);
    inflight     = {1'b0, outstanding} + {1'b0, count};
    pop          = head_vld & ~bus.stall & ~bus.redirect_valid;
    // A slot freed by this cycle's pop may be reused by this cycle's request.
    req_vld      = rst_n & ~bus.redirect_valid & (inflight < (pop ? 3'd3 : 3'd2));
    accept       = req_vld & bus.imem_req_ready;
    // Responses with nothing outstanding are stray and leave all state alone.
    resp_ok      = bus.imem_resp_valid & (outstanding != 2'd0);
    push         = resp_ok & (drop == 2'd0) & ~bus.redirect_valid;
    redir_target = bus.redirect_pc & ~32'h3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= 2'd0;
      drop        <= 2'd0;
      count       <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      q_pc[0]     <= 32'h0;
      q_pc[1]     <= 32'h0;
      q_inst[0]   <= 32'h0;
      q_inst[1]   <= 32'h0;
    end else if (bus.redirect_valid) begin
      // Everything still in flight belongs to the old path; a response landing now is discarded too.
      pc          <= redir_target;
      resp_pc     <= redir_target;
      outstanding <= outstanding - {1'b0, resp_ok};
      drop        <= outstanding - {1'b0, resp_ok};
      count       <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
    end else begin
      if (accept) begin
        pc <= pc + 32'd4;
      end
      outstanding <= outstanding + {1'b0, accept} - {1'b0, resp_ok};
      if (resp_ok && drop != 2'd0) begin
        drop <= drop - 2'd1;
      end
      if (push) begin
        q_pc[wr_ptr]   <= resp_pc;
        q_inst[wr_ptr] <= bus.imem_resp_data;
        wr_ptr         <= ~wr_ptr;
        resp_pc        <= resp_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign bus.imem_req_valid = req_vld;
  assign bus.imem_req_addr  = pc;
  assign bus.inst_valid     = head_vld;
  assign bus.inst_out       = head_vld ? q_inst[rd_ptr] : 32'h0;
  assign bus.pc_out         = head_vld ? q_pc[rd_ptr] : resp_pc;
endmodule

// File: tb/tb_pipeline_fetch.sv
// Bench for pipeline_fetch: cycle table for fill/stall, directed redirect/not-ready/reset
// sequences, then random traffic checked against an expected-address-stream model.
module tb_pipeline_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic        stall;
    logic        iv;
    logic [31:0] pc;
    logic        rv;
    logic [31:0] addr;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  pipeline_fetch_if bus();

  pipeline_fetch #(.RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          failed = 0;
  int          cyc = 0;
  int          pops = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  mreq_t       mq[$];
  logic [31:0] exp_pc = RST_PC;
  logic [31:0] exp_req = RST_PC;
  logic        prev_redir = 1'b0;
  logic [31:0] prev_target = 32'h0;

  logic        nx_rst = 1'b0;
  logic        nx_stall = 1'b0;
  logic        nx_ready = 1'b1;
  logic        nx_redir = 1'b0;
  logic [31:0] nx_rpc = 32'h0;
  logic        nx_pulse = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected behaviour: consumed instructions and issued requests each form a
  // sequential address stream that restarts at the redirect target or RESET_PC.
  task automatic monitor();
    logic do_pop;
    if (!rst_n) begin
      chk("rst_inst_valid", 32'(bus.inst_valid), 32'h0);
      chk("rst_inst_out", bus.inst_out, 32'h0);
      chk("rst_pc_out", bus.pc_out, RST_PC);
      chk("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
      exp_pc = RST_PC;
      exp_req = RST_PC;
      prev_redir = 1'b0;
      mq.delete();
      return;
    end
    if (bus.imem_resp_valid) void'(mq.pop_front());
    if (prev_redir) begin
      chk("redir_next_valid", 32'(bus.inst_valid), 32'h0);
      chk("redir_next_pc", bus.pc_out, prev_target);
    end
    if (!bus.inst_valid) chk("empty_nop", bus.inst_out, 32'h0);
    do_pop = bus.inst_valid & ~bus.stall & ~bus.redirect_valid;
    if (do_pop) begin
      chk("pop_pc", bus.pc_out, exp_pc);
      chk("pop_inst", bus.inst_out, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (bus.redirect_valid) begin
      chk("redir_no_req", 32'(bus.imem_req_valid), 32'h0);
      exp_pc = bus.redirect_pc & ~32'h3;
      exp_req = exp_pc;
      prev_target = exp_pc;
      prev_redir = 1'b1;
    end else begin
      prev_redir = 1'b0;
      if (bus.imem_req_valid) chk("req_addr", bus.imem_req_addr, exp_req);
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        mq.push_back('{addr: bus.imem_req_addr, due: cyc + $urandom_range(lat_min, lat_max)});
        exp_req = exp_req + 32'd4;
      end
    end
    chk("inflight_le2", 32'(mq.size() <= 2), 32'h1);
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    rst_n = nx_rst;
    bus.stall = nx_stall;
    bus.imem_req_ready = nx_ready;
    bus.redirect_valid = nx_redir;
    bus.redirect_pc = nx_rpc;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data = mem_word(mq[0].addr);
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data = $urandom;
    end
    if (nx_pulse) begin
      // Reset pulse between edges; any response now driven becomes a stray.
      #1 rst_n = 1'b0;
      #1;
      chk("pulse_inst_valid", 32'(bus.inst_valid), 32'h0);
      chk("pulse_inst_out", bus.inst_out, 32'h0);
      chk("pulse_pc_out", bus.pc_out, RST_PC);
      chk("pulse_req_valid", 32'(bus.imem_req_valid), 32'h0);
      rst_n = 1'b1;
      exp_pc = RST_PC;
      exp_req = RST_PC;
      prev_redir = 1'b0;
    end
    @(negedge clk);
    monitor();
  endtask

  task automatic do_reset(input int lat);
    lat_min = lat;
    lat_max = lat;
    nx_stall = 1'b0;
    nx_ready = 1'b1;
    nx_redir = 1'b0;
    nx_rst = 1'b0;
    tick();
    tick();
    nx_rst = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] target);
    nx_redir = 1'b1;
    nx_rpc = target;
    tick();
    nx_redir = 1'b0;
  endtask

  task automatic wait_valid(input string name, input logic [31:0] want_pc);
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (bus.inst_valid) seen = 1'b1;
    end
    if (seen) begin
      chk({name, "_pc"}, bus.pc_out, want_pc);
      chk({name, "_inst"}, bus.inst_out, mem_word(want_pc));
    end else begin
      chk({name, "_timeout"}, 32'h0, 32'h1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run", tests);
    $fatal(1);
  end

  initial begin
    vec_t        tbl[12];
    logic [31:0] hold_addr;
    int          pops_before;

    tbl[0]  = '{1'b0, 1'b0, 32'h100, 1'b1, 32'h100};
    tbl[1]  = '{1'b0, 1'b0, 32'h100, 1'b1, 32'h104};
    tbl[2]  = '{1'b1, 1'b1, 32'h100, 1'b0, 32'h108};
    tbl[3]  = '{1'b1, 1'b1, 32'h100, 1'b0, 32'h108};
    tbl[4]  = '{1'b1, 1'b1, 32'h100, 1'b0, 32'h108};
    tbl[5]  = '{1'b1, 1'b1, 32'h100, 1'b0, 32'h108};
    tbl[6]  = '{1'b1, 1'b1, 32'h100, 1'b0, 32'h108};
    tbl[7]  = '{1'b0, 1'b1, 32'h100, 1'b1, 32'h108};
    tbl[8]  = '{1'b0, 1'b1, 32'h104, 1'b1, 32'h10c};
    tbl[9]  = '{1'b0, 1'b1, 32'h108, 1'b1, 32'h110};
    tbl[10] = '{1'b0, 1'b1, 32'h10c, 1'b1, 32'h114};
    tbl[11] = '{1'b0, 1'b1, 32'h110, 1'b1, 32'h118};

    bus.imem_req_ready = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.stall = 1'b0;

    // Reset, fill, 5-cycle stall after first valid, then streaming (1-cycle memory).
    do_reset(1);
    for (int i = 0; i < 12; i++) begin
      nx_stall = tbl[i].stall;
      tick();
      chk($sformatf("tbl%0d_iv", i), 32'(bus.inst_valid), 32'(tbl[i].iv));
      chk($sformatf("tbl%0d_pc", i), bus.pc_out, tbl[i].pc);
      chk($sformatf("tbl%0d_inst", i), bus.inst_out, tbl[i].iv ? mem_word(tbl[i].pc) : 32'h0);
      chk($sformatf("tbl%0d_rv", i), 32'(bus.imem_req_valid), 32'(tbl[i].rv));
      chk($sformatf("tbl%0d_addr", i), bus.imem_req_addr, tbl[i].addr);
    end
    nx_stall = 1'b0;

    // Memory not ready for 4 cycles: address frozen, queue drains.
    hold_addr = exp_req;
    nx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("nrdy_addr", bus.imem_req_addr, hold_addr);
    end
    chk("nrdy_drained", 32'(bus.inst_valid), 32'h0);
    chk("nrdy_req_valid", 32'(bus.imem_req_valid), 32'h1);
    nx_ready = 1'b1;
    wait_valid("nrdy_resume", hold_addr);

    // Async reset pulse mid-stream; the response in flight arrives as a stray.
    repeat (3) tick();
    nx_pulse = 1'b1;
    nx_ready = 1'b0;
    tick();
    nx_pulse = 1'b0;
    tick();
    nx_ready = 1'b1;
    wait_valid("pulse_restart", RST_PC);

    // Redirect with two requests in flight (3-cycle memory).
    do_reset(3);
    tick();
    tick();
    chk("two_inflight", 32'(mq.size()), 32'd2);
    redirect(32'h0000_2000);
    wait_valid("redir_inflight", 32'h0000_2000);

    // Redirect in the same cycle as a response (2-cycle memory), unaligned target.
    do_reset(2);
    tick();
    tick();
    redirect(32'h0000_0043);
    wait_valid("redir_coincide", 32'h0000_0040);

    // Random traffic.
    lat_min = 1;
    lat_max = 3;
    pops_before = pops;
    for (int i = 0; i < 3000; i++) begin
      nx_stall = ($urandom_range(0, 9) < 3);
      nx_ready = ($urandom_range(0, 9) < 7);
      nx_redir = ($urandom_range(0, 19) == 0);
      nx_rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      tick();
    end
    nx_stall = 1'b0;
    nx_ready = 1'b1;
    nx_redir = 1'b0;
    repeat (10) tick();
    chk("random_progress", 32'(pops - pops_before > 200), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/pipeline_fetch.md
# pipeline_fetch

Instruction-fetch stage of the MIPS pipeline. It owns the program counter, issues word reads to instruction memory over a valid/ready request channel with in-order responses, and buffers returned words in a 2-entry queue. It presents `{pc, instruction}` to the register-fetch stage, which decodes rs/rt from the instruction. It handles downstream stalls and branch/jump redirects, including discarding responses still in flight from the old path.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset; bits [1:0] must be 0.

- `clk`  in  1: clock; all state updates on posedge.
- `rst_n`  in  1: reset; asynchronous, active-low.
- `imem_req_valid`  out  1: read request valid.
- `imem_req_ready`  in  1: memory accepts the request this cycle.
- `imem_req_addr`  out  32: word address of the request; driven straight from the PC register.
- `imem_resp_valid`  in  1: response word valid. Responses arrive in request order, at least 1 cycle after acceptance.
- `imem_resp_data`  in  32: instruction word.
- `redirect_valid`  in  1: single-cycle pulse from execute; branch/jump taken.
- `redirect_pc`  in  32: new fetch address; bits [1:0] forced to 0.
- `stall`  in  1: downstream cannot accept this cycle.
- `inst_valid`  out  1: queue head holds a valid instruction.
- `inst_out`  out  32: instruction at the queue head.
- `pc_out`  out  32: address of `inst_out`.

## Operation
**State**
- `pc`: next request address.
- `resp_pc`: address of the next live response.
- `outstanding`: 0..2, accepted requests without a response, including ones marked for dropping.
- `drop`: 0..2, upcoming responses to discard.
- 2-entry FIFO of `{pc, inst}` with `count` 0..2.

**Request issue**
- `pop` = `inst_valid & ~stall & ~redirect_valid`.
- `imem_req_valid` = `rst_n & ~redirect_valid & (outstanding + count - pop < 2)`.
- On accept (`valid & ready`): `pc <= pc + 4` (wraps modulo 2^32) and `outstanding` increments.

**Response handling**
- A response decrements `outstanding`.
- If `drop > 0`: decrement `drop` and discard the data.
- Otherwise: push `{resp_pc, imem_resp_data}`, then `resp_pc <= resp_pc + 4`.
- A response arriving with `outstanding == 0` is a protocol violation; ignore it and leave all state unchanged.

**Pop**
- When `pop`, the head is removed.
- Push and pop in the same cycle: `count` unchanged and the order is preserved.

**Redirect** (highest priority)
- FIFO is flushed (`count <= 0`).
- `pc <= redirect_pc` and `resp_pc <= redirect_pc`.
- `drop <= outstanding` minus 1 if a response arrives in the same cycle. That response is discarded and also decrements `outstanding`.
- No request is issued and no pop occurs in the redirect cycle.

**Empty FIFO**
- `inst_out` = 32'h0 (NOP) and `pc_out` = `resp_pc`. `inst_valid` is 0.

**Invariants**
- `outstanding + count ≤ 2` at all times, so the FIFO never overflows.
- `drop ≤ outstanding`.

## Timing
- Reset (async assert, sync release):
  - `pc = resp_pc = RESET_PC`.
  - `outstanding = drop = count = 0`.
  - FIFO entries 0.
  - `inst_valid = 0`, `inst_out = 0`, `pc_out = RESET_PC`, `imem_req_valid = 0` while `rst_n` is low.
- First request is offered in the first cycle after `rst_n` rises.
- Response to output: a response in cycle N appears on `inst_out` with `inst_valid = 1` in cycle N+1 when the FIFO was empty.
- Throughput: with 1-cycle memory latency, `imem_req_ready = 1` and no stall, one instruction per cycle after a 2-cycle fill.
- Redirect in cycle N:
  - `inst_valid = 0` in N+1.
  - The request to `redirect_pc` is offered in N+1.
  - The first redirected instruction appears no earlier than N+3.
- Reset mid-operation: all state is cleared immediately. In-flight responses arriving after reset is released are protocol violations and are ignored (`outstanding == 0`).
- Stall held indefinitely: the FIFO fills to 2, `imem_req_valid` drops, and the outputs remain stable.

## Test plan
- **Reset and fill**: `RESET_PC` = 0x100, memory with 1-cycle latency always ready. Required response:
  - Requests go to 0x100, 0x104, 0x108, …
  - `pc_out` sequence 0x100, 0x104, … with matching data.
  - After fill, one instruction per cycle.
- **Stall backpressure**: assert `stall` for 5 cycles after the first valid instruction. Required response:
  - `inst_out`/`pc_out` held at 0x100.
  - `imem_req_valid` low once `outstanding + count == 2`.
  - On release, 0x104 follows with no loss or duplication.
- **Redirect with responses in flight**: 3-cycle memory latency, 2 outstanding, `redirect_valid` with `redirect_pc` = 0x2000. Required response:
  - Both old responses are discarded.
  - The next `inst_valid` shows `pc_out` = 0x2000 with the 0x2000 data.
- **Redirect coinciding with a response**: a response arrives in the same cycle as the redirect to 0x40. Required response:
  - That word never appears.
  - `drop` = `outstanding` − 1.
  - First output is `pc_out` = 0x40.
- **Memory not ready**: hold `imem_req_ready` low for 4 cycles. Required response:
  - `imem_req_addr` stays stable.
  - `pc` does not advance.
  - `inst_valid` goes low once the FIFO drains.
- **Async reset mid-stream**: pulse `rst_n` low between clock edges. Required response:
  - Outputs go to their reset values immediately.
  - Fetch restarts at `RESET_PC`.
  - A stray late response is ignored.
